// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait ARQ sender: pushes one word at a time into the datapath and
// retransmits on nack or timeout until acknowledged or retries are exhausted.
module arq_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 16,
  localparam int RW = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1),
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ack,
  input  logic                  nack,
  output logic                  busy,
  output logic                  ok,
  output logic                  fail,
  output logic [RW-1:0]         retry_cnt,
  output logic [7:0]            ok_cnt,
  output logic [7:0]            fail_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [7:0]            ok_cnt_q, ok_cnt_d;
  logic [7:0]            fail_cnt_q, fail_cnt_d;
  logic                  ok_q, ok_d;
  logic                  fail_q, fail_d;

  // NOTE: non-blocking assignments keep every register sampling the pre-edge
  // values, so evaluation order between flops cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      ok_cnt_q   <= ok_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    ok_cnt_d   = ok_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ok_d       = 1'b0;
    fail_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          hold_d  = in_data;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // ack wins over nack, and either response pre-empts the timeout
        if (ack) begin
          ok_d     = 1'b1;
          ok_cnt_d = (ok_cnt_q == 8'hFF) ? ok_cnt_q : ok_cnt_q + 8'd1;
          state_d  = IDLE;
        end else if (nack || (timer_q == TW'(TIMEOUT - 1))) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            fail_d     = 1'b1;
            fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
            state_d    = IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign wr_en     = (state_q == SEND);
  assign wr_data   = hold_q;
  assign busy      = (state_q != IDLE);
  assign ok        = ok_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign ok_cnt    = ok_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// Directed bench for arq_tx_ctrl: a scoreboard of expected writes and
// outcomes is filled as stimulus is driven and drained as the DUT responds.
module tb_arq_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ack;
  logic       nack;
  logic       busy;
  logic       ok;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] ok_cnt;
  logic [7:0] fail_cnt;

  typedef struct packed {
    logic       is_ok;
    logic [1:0] retry;
  } res_t;

  logic [7:0] exp_wr[$];
  res_t       exp_res[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;

  arq_tx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ack       (ack),
    .nack      (nack),
    .busy      (busy),
    .ok        (ok),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .ok_cnt    (ok_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample at the falling edge and drain the scoreboard.
  task automatic tick();
    res_t r;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (wr_en === 1'b1) begin
        if (exp_wr.size() == 0) check("wr_unexpected", {31'd0, wr_en}, 32'd0);
        else check("wr_data", {24'd0, wr_data}, {24'd0, exp_wr.pop_front()});
      end
      if (ok === 1'b1 || fail === 1'b1) begin
        if (exp_res.size() == 0) check("result_unexpected", {30'd0, ok, fail}, 32'd0);
        else begin
          r = exp_res.pop_front();
          check("ok_pulse", {31'd0, ok}, {31'd0, r.is_ok});
          check("fail_pulse", {31'd0, fail}, {31'd0, !r.is_ok});
          check("retry_at_result", {30'd0, retry_cnt}, {30'd0, r.retry});
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a word for one cycle; wr_en must follow on the very next cycle.
  task automatic send_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    exp_wr.push_back(d);
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    check("latency_wr_en", {31'd0, wr_en}, 32'd1);
    check("busy_in_send", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_wr(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (wr_en !== 1'b1 && n < bound);
    check("wait_wr_bound", {31'd0, wr_en}, 32'd1);
  endtask

  task automatic wait_res(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (ok !== 1'b1 && fail !== 1'b1 && n < bound);
    check("wait_result_bound", {31'd0, (ok | fail)}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ok"}, {31'd0, ok}, 32'd0);
    check({tag, "_fail"}, {31'd0, fail}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_retry_cnt"}, {30'd0, retry_cnt}, 32'd0);
    check({tag, "_ok_cnt"}, {24'd0, ok_cnt}, 32'd0);
    check({tag, "_fail_cnt"}, {24'd0, fail_cnt}, 32'd0);
  endtask

  initial begin
    int prev;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ack      = 1'b0;
    nack     = 1'b0;

    // Power-on reset, then reset asserted mid-transfer between clock edges.
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_por_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_por_busy", {31'd0, busy}, 32'd0);

    send_word(8'h11);
    ticks(2);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single send acked on the third WAIT cycle.
    send_word(8'hA5);
    ticks(3);
    check("a5_no_retx", {24'd0, wr_data}, 32'hA5);
    ack = 1'b1;
    exp_res.push_back('{is_ok: 1'b1, retry: 2'd0});
    tick();
    ack = 1'b0;
    check("a5_ok_seen", {31'd0, ok}, 32'd1);
    check("a5_in_ready_with_ok", {31'd0, in_ready}, 32'd1);
    check("a5_ok_cnt", {24'd0, ok_cnt}, 32'd1);
    check("a5_retry_cnt", {30'd0, retry_cnt}, 32'd0);

    // Two nacks then ack: three identical transmissions.
    send_word(8'h3C);
    for (int k = 0; k < 2; k++) begin
      tick();
      nack = 1'b1;
      exp_wr.push_back(8'h3C);
      tick();
      nack = 1'b0;
      check("3c_retx_wr_en", {31'd0, wr_en}, 32'd1);
    end
    tick();
    ack = 1'b1;
    exp_res.push_back('{is_ok: 1'b1, retry: 2'd2});
    tick();
    ack = 1'b0;
    check("3c_ok_seen", {31'd0, ok}, 32'd1);
    check("3c_retry_cnt", {30'd0, retry_cnt}, 32'd2);
    check("3c_fail_cnt", {24'd0, fail_cnt}, 32'd0);
    check("3c_ok_cnt", {24'd0, ok_cnt}, 32'd2);

    // No response at all: four sends 17 cycles apart, then fail.
    exp_res.push_back('{is_ok: 1'b0, retry: 2'd3});
    send_word(8'hFF);
    prev = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_wr.push_back(8'hFF);
      wait_wr(30);
      check("ff_spacing", cyc - prev, 32'd17);
      prev = cyc;
    end
    wait_res(30);
    check("ff_fail_spacing", cyc - prev, 32'd17);
    check("ff_fail_cnt", {24'd0, fail_cnt}, 32'd1);
    check("ff_retry_cnt", {30'd0, retry_cnt}, 32'd3);
    check("ff_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("ff_retry_held", {30'd0, retry_cnt}, 32'd3);

    // ack and nack together count as ack; stray pulses in IDLE do nothing.
    send_word(8'h5A);
    ticks(2);
    ack  = 1'b1;
    nack = 1'b1;
    exp_res.push_back('{is_ok: 1'b1, retry: 2'd0});
    tick();
    ack  = 1'b0;
    nack = 1'b0;
    check("5a_ok_seen", {31'd0, ok}, 32'd1);
    ack = 1'b1;
    tick();
    ack  = 1'b0;
    nack = 1'b1;
    tick();
    nack = 1'b0;
    ticks(3);
    check("idle_pulses_busy", {31'd0, busy}, 32'd0);
    check("idle_pulses_ok_cnt", {24'd0, ok_cnt}, 32'd3);
    check("idle_pulses_fail_cnt", {24'd0, fail_cnt}, 32'd1);
    check("idle_pulses_res_q", exp_res.size(), 32'd0);

    // Reset while waiting after two retries: word abandoned, counters cleared.
    send_word(8'h77);
    for (int k = 0; k < 2; k++) begin
      tick();
      nack = 1'b1;
      exp_wr.push_back(8'h77);
      tick();
      nack = 1'b0;
    end
    check("77_retry_before_rst", {30'd0, retry_cnt}, 32'd2);
    ticks(2);
    #2 rst = 1'b1;
    #1;
    check_all_zero("wait_rst");
    @(negedge clk);
    rst = 1'b0;
    ticks(20);
    check("wait_rst_busy", {31'd0, busy}, 32'd0);
    check("wait_rst_wr_q", exp_wr.size(), 32'd0);

    // Back-to-back acked words saturate ok_cnt at 255.
    for (int i = 0; i < 300; i++) begin
      send_word(8'(i));
      tick();
      ack = 1'b1;
      exp_res.push_back('{is_ok: 1'b1, retry: 2'd0});
      tick();
      ack = 1'b0;
      if (i == 253) check("sat_ok_cnt_254", {24'd0, ok_cnt}, 32'd254);
      if (i == 254) check("sat_ok_cnt_255", {24'd0, ok_cnt}, 32'd255);
    end
    check("sat_ok_cnt_final", {24'd0, ok_cnt}, 32'd255);
    check("sat_fail_cnt", {24'd0, fail_cnt}, 32'd0);
    ticks(2);
    check("final_wr_q_empty", exp_wr.size(), 32'd0);
    check("final_res_q_empty", exp_res.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
